// File: rtl/TriggerTypes.sv
// Shared trigger-protocol types: responder return codes and responder FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package TriggerTypes;

  // Return codes reported on ap_return; 32 bits wide so they drop straight onto the bus.
  typedef enum logic [31:0] {
    EXECUTED    = 32'd1,
    WAIT_INPUT  = 32'd2,
    WAIT_OUTPUT = 32'd3
  } ret_code_e;

  // Actor responder control states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_FIRE,
    ST_WAIT_ACT,
    ST_SETTLE,
    ST_DONE
  } resp_state_e;

endpackage

// File: rtl/actor_fire_predicate.sv
// Firing-rule predicates: every input has enough tokens, every output has enough space.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to sample the result.
//
// Ports:
//   in_count/in_need   : packed per-input token counts and per-firing consumption (need 0 = port not required)
//   out_space/out_need : packed per-output free slots and per-firing production
//   in_ok/out_ok       : unsigned >= test ANDed across all ports
module actor_fire_predicate #(
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_OUTPUTS = 1,
  parameter int CNT_W       = 16
) (
  input  logic [NUM_INPUTS*CNT_W-1:0]  in_count,
  input  logic [NUM_INPUTS*CNT_W-1:0]  in_need,
  input  logic [NUM_OUTPUTS*CNT_W-1:0] out_space,
  input  logic [NUM_OUTPUTS*CNT_W-1:0] out_need,
  output logic                         in_ok,
  output logic                         out_ok
);

  always_comb begin
    in_ok = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (in_count[i*CNT_W +: CNT_W] < in_need[i*CNT_W +: CNT_W]) begin
        in_ok = 1'b0;
      end
    end
  end

  always_comb begin
    out_ok = 1'b1;
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      if (out_space[j*CNT_W +: CNT_W] < out_need[j*CNT_W +: CNT_W]) begin
        out_ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/actor_responder.sv
// Actor-side responder: on launch, fires the action kernel while the firing rules pass, then reports a return code.
// Latency: 2 cycles launch-to-done with no firing; each firing adds at least 3 cycles (FIRE, SETTLE, EVAL).
// Backpressure: action_start is held until action_ready; ap_start is only accepted in IDLE.
//
// Ports:
//   ap_clk/ap_rst                  : clock, synchronous active-high reset
//   ap_start/ap_done/ap_ready/ap_idle/ap_return : trigger-side ap_ctrl_hs handshake and 32-bit return code
//   in_count/in_need/out_space/out_need         : FIFO occupancy and per-firing token requirements
//   action_start/action_ready/action_done       : kernel launch handshake
//   total_firings                  : wrapping count of firings since reset
module actor_responder
  import TriggerTypes::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int NUM_OUTPUTS = 1,
  parameter int CNT_W       = 16,
  parameter int MAX_FIRINGS = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ap_start,
  output logic                         ap_done,
  output logic                         ap_ready,
  output logic                         ap_idle,
  output logic [31:0]                  ap_return,
  input  logic [NUM_INPUTS*CNT_W-1:0]  in_count,
  input  logic [NUM_INPUTS*CNT_W-1:0]  in_need,
  input  logic [NUM_OUTPUTS*CNT_W-1:0] out_space,
  input  logic [NUM_OUTPUTS*CNT_W-1:0] out_need,
  output logic                         action_start,
  input  logic                         action_ready,
  input  logic                         action_done,
  output logic [31:0]                  total_firings
);

  localparam int                 FIRED_W   = $clog2(MAX_FIRINGS + 1);
  localparam logic [FIRED_W-1:0] FIRED_MAX = FIRED_W'(MAX_FIRINGS);

  resp_state_e        state_q, state_d;
  logic [FIRED_W-1:0] fired_q, fired_d;
  logic [31:0]        total_q, total_d;
  logic [31:0]        ret_q, ret_d;
  logic               in_ok, out_ok;
  logic               fire_ack;

  actor_fire_predicate #(
    .NUM_INPUTS (NUM_INPUTS),
    .NUM_OUTPUTS(NUM_OUTPUTS),
    .CNT_W      (CNT_W)
  ) u_pred (
    .in_count (in_count),
    .in_need  (in_need),
    .out_space(out_space),
    .out_need (out_need),
    .in_ok    (in_ok),
    .out_ok   (out_ok)
  );

  // A kernel completion only counts while a firing is outstanding; stray dones are dropped.
  assign fire_ack = ((state_q == ST_FIRE) && action_ready && action_done) ||
                    ((state_q == ST_WAIT_ACT) && action_done);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      fired_q <= '0;
      total_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      fired_q <= fired_d;
      total_q <= total_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fired_d = fired_q;
    total_d = total_q;
    ret_d   = ret_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          state_d = ST_EVAL;
          fired_d = '0;
        end
      end
      ST_EVAL: begin
        if (fired_q == FIRED_MAX) begin
          state_d = ST_DONE;
          ret_d   = EXECUTED;
        end else if (in_ok && out_ok) begin
          state_d = ST_FIRE;
        end else begin
          state_d = ST_DONE;
          // Any progress this invocation wins; otherwise starvation outranks back-pressure.
          if (fired_q != '0)  ret_d = EXECUTED;
          else if (!in_ok)    ret_d = WAIT_INPUT;
          else                ret_d = WAIT_OUTPUT;
        end
      end
      ST_FIRE: begin
        if (action_ready) begin
          state_d = action_done ? ST_SETTLE : ST_WAIT_ACT;
        end
      end
      ST_WAIT_ACT: begin
        if (action_done) state_d = ST_SETTLE;
      end
      // Gives the FIFOs one cycle to reflect the firing before predicates are re-sampled.
      ST_SETTLE: state_d = ST_EVAL;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // FIRE is only entered with fired_q < MAX_FIRINGS, so this cannot wrap.
    if (fire_ack) begin
      fired_d = fired_q + FIRED_W'(1);
      total_d = total_q + 32'd1;
    end
  end

  always_comb begin
    ap_done       = (state_q == ST_DONE);
    ap_ready      = ap_done;
    ap_idle       = (state_q == ST_IDLE);
    action_start  = (state_q == ST_FIRE);
    ap_return     = ret_q;
    total_firings = total_q;
  end

endmodule

// File: tb/tb_actor_responder.sv
// Self-checking bench for actor_responder: scoreboarded invocations with a behavioural kernel.
// Latency: checks launch-to-done latency where it is deterministic.
// Backpressure: exercises delayed action_ready and split ready/done handshakes.
module tb_actor_responder;

  localparam int NI    = 2;
  localparam int NO    = 1;
  localparam int CW    = 16;
  localparam int MAXF  = 4;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic              ap_start = 1'b0;
  logic              ap_done, ap_ready, ap_idle;
  logic [31:0]       ap_return;
  logic [NI*CW-1:0]  in_count = '0;
  logic [NI*CW-1:0]  in_need  = '0;
  logic [NO*CW-1:0]  out_space = '0;
  logic [NO*CW-1:0]  out_need  = '0;
  logic              action_start;
  logic              action_ready = 1'b0;
  logic              action_done  = 1'b0;
  logic [31:0]       total_firings;

  int n_checks = 0;
  int n_fail   = 0;
  int tot_model = 0;

  typedef struct {
    logic [31:0] ret;
    int          fires;
  } exp_t;
  exp_t sb_q[$];

  always #5 ap_clk = ~ap_clk;

  actor_responder #(
    .NUM_INPUTS (NI),
    .NUM_OUTPUTS(NO),
    .CNT_W      (CW),
    .MAX_FIRINGS(MAXF)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_ready     (ap_ready),
    .ap_idle      (ap_idle),
    .ap_return    (ap_return),
    .in_count     (in_count),
    .in_need      (in_need),
    .out_space    (out_space),
    .out_need     (out_need),
    .action_start (action_start),
    .action_ready (action_ready),
    .action_done  (action_done),
    .total_firings(total_firings)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Kernel finishes a firing: tokens are consumed from inputs and produced into outputs.
  task automatic kernel_done(input bit consume);
    action_done = 1'b1;
    tot_model++;
    if (consume) begin
      in_count[15:0]  = in_count[15:0]  - in_need[15:0];
      in_count[31:16] = in_count[31:16] - in_need[31:16];
      out_space       = out_space - out_need;
    end
  endtask

  task automatic run_inv(input string name, input logic [31:0] exp_ret, input int exp_fires,
                         input int exp_lat, input int rdy_dly, input int done_dly,
                         input bit consume, input bit mid_start);
    int   cyc;
    int   fires;
    int   rwait;
    int   dwait;
    bit   pending;
    bit   seen;
    exp_t e;
    cyc = 0; fires = 0; rwait = 0; dwait = 0; pending = 0; seen = 0;
    sb_q.push_back('{ret: exp_ret, fires: exp_fires});
    ap_start = 1'b1;
    @(negedge ap_clk);
    cyc = 1;
    while (cyc < 400) begin
      action_ready = 1'b0;
      action_done  = 1'b0;
      ap_start     = 1'b0;
      if (ap_done) begin
        seen = 1;
        break;
      end
      if (!pending && action_start && dwait == 0) pending = 1;
      if (pending) begin
        chk({name, "_start_held"}, {31'd0, action_start}, 32'd1);
        if (rwait < rdy_dly) begin
          rwait++;
          if (mid_start && rwait == 2) ap_start = 1'b1;
        end else begin
          action_ready = 1'b1;
          pending = 0;
          rwait = 0;
          fires++;
          if (done_dly == 0) kernel_done(consume);
          else dwait = done_dly;
        end
      end else if (dwait > 0) begin
        dwait--;
        if (dwait == 0) kernel_done(consume);
      end
      @(negedge ap_clk);
      cyc++;
    end
    if (!seen) begin
      chk({name, "_timeout"}, {31'd0, ap_done}, 32'd1);
    end else begin
      if (sb_q.size() == 0) begin
        chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk({name, "_ret"}, ap_return, e.ret);
        chk({name, "_fires"}, 32'(fires), 32'(e.fires));
      end
      chk({name, "_ready"}, {31'd0, ap_ready}, 32'd1);
      if (exp_lat >= 0) chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
      chk({name, "_total"}, total_firings, 32'(tot_model));
      @(negedge ap_clk);
      chk({name, "_idle_after"}, {31'd0, ap_idle}, 32'd1);
      for (int k = 0; k < 3; k++) begin
        chk({name, "_no_extra_done"}, {31'd0, ap_done}, 32'd0);
        chk({name, "_no_extra_start"}, {31'd0, action_start}, 32'd0);
        @(negedge ap_clk);
      end
    end
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("rst_idle", {31'd0, ap_idle}, 32'd1);
    chk("rst_done", {31'd0, ap_done}, 32'd0);
    chk("rst_ready", {31'd0, ap_ready}, 32'd0);
    chk("rst_action_start", {31'd0, action_start}, 32'd0);
    chk("rst_return", ap_return, 32'd0);
    chk("rst_total", total_firings, 32'd0);

    // Input 0 starved.
    in_count = {16'd5, 16'd0}; in_need = {16'd1, 16'd1};
    out_space = 16'd2; out_need = 16'd1;
    run_inv("starve", 32'd2, 0, 2, 0, 0, 1'b0, 1'b0);

    // Output space limits the run to two firings.
    in_count = {16'd3, 16'd3}; in_need = {16'd1, 16'd1};
    out_space = 16'd2; out_need = 16'd1;
    run_inv("two_fire", 32'd1, 2, 8, 0, 0, 1'b1, 1'b0);

    // No output space at all.
    in_count = {16'd9, 16'd9}; in_need = {16'd1, 16'd1};
    out_space = 16'd0; out_need = 16'd1;
    run_inv("backpress", 32'd3, 0, 2, 0, 0, 1'b0, 1'b0);

    // Unlimited resources: firing budget caps each invocation.
    in_count = {16'hFFFF, 16'hFFFF}; in_need = {16'd1, 16'd1};
    out_space = 16'hFFFF; out_need = 16'd1;
    run_inv("budget_a", 32'd1, MAXF, 2 + 3 * MAXF, 0, 0, 1'b0, 1'b0);
    run_inv("budget_b", 32'd1, MAXF, 2 + 3 * MAXF, 0, 0, 1'b0, 1'b0);

    // Slow kernel acceptance, split done, and an ignored launch pulse mid-firing.
    in_count = {16'd1, 16'd1}; in_need = {16'd1, 16'd1};
    out_space = 16'd4; out_need = 16'd1;
    run_inv("slow_kernel", 32'd1, 1, -1, 5, 2, 1'b1, 1'b1);

    // A zero need means the empty port does not block firing.
    in_count = {16'd2, 16'd0}; in_need = {16'd1, 16'd0};
    out_space = 16'd8; out_need = 16'd1;
    run_inv("zero_need", 32'd1, 2, 8, 0, 0, 1'b1, 1'b0);

    // Reset while waiting on the kernel.
    in_count = {16'd4, 16'd4}; in_need = {16'd1, 16'd1};
    out_space = 16'd4; out_need = 16'd1;
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    cyc = 0;
    while (!action_start && cyc < 20) begin
      @(negedge ap_clk);
      cyc++;
    end
    chk("rst_test_fire_reached", {31'd0, action_start}, 32'd1);
    action_ready = 1'b1;
    @(negedge ap_clk);
    action_ready = 1'b0;
    chk("wait_act_start_low", {31'd0, action_start}, 32'd0);
    chk("wait_act_not_idle", {31'd0, ap_idle}, 32'd0);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    tot_model = 0;
    chk("midrst_idle", {31'd0, ap_idle}, 32'd1);
    chk("midrst_action_start", {31'd0, action_start}, 32'd0);
    chk("midrst_return", ap_return, 32'd0);
    chk("midrst_done", {31'd0, ap_done}, 32'd0);
    chk("midrst_total", total_firings, 32'(tot_model));
    action_done = 1'b1;
    @(negedge ap_clk);
    action_done = 1'b0;
    @(negedge ap_clk);
    chk("late_done_total", total_firings, 32'(tot_model));
    chk("late_done_idle", {31'd0, ap_idle}, 32'd1);
    chk("late_done_start", {31'd0, action_start}, 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/actor_responder.md
# actor_responder

Actor-side responder for the trigger launch protocol. It accepts the one-cycle launch pulse and repeatedly evaluates firing rules against FIFO token counts and free space. For each rule that passes it fires the action kernel through an ap_ctrl_hs-style handshake. It then reports a 32-bit return code (EXECUTED / WAIT_INPUT / WAIT_OUTPUT) together with done/ready/idle back to the trigger.

## Interface
- NUM_INPUTS, 2: number of input FIFO ports (≥1)
- NUM_OUTPUTS, 1: number of output FIFO ports (≥1)
- CNT_W, 16: width of token-count, space and need fields
- MAX_FIRINGS, 16: firing budget per invocation (≥1)
- ap_clk  in  1  clock; one clock domain
- ap_rst  in  1  reset; synchronous, active-high
- ap_start  in  1  launch pulse from the trigger
- ap_done  out  1  invocation complete; ap_return is valid this cycle
- ap_ready  out  1  equals ap_done
- ap_idle  out  1  high only in IDLE
- ap_return  out  32  return code; registered, held until the next launch
- in_count  in  NUM_INPUTS*CNT_W  tokens available per input port (port i at bits [i*CNT_W +: CNT_W])
- in_need  in  NUM_INPUTS*CNT_W  tokens consumed per firing; 0 means the port is not required
- out_space  in  NUM_OUTPUTS*CNT_W  free slots per output port
- out_need  in  NUM_OUTPUTS*CNT_W  tokens produced per firing
- action_start  out  1  start request to the action kernel
- action_ready  in  1  kernel accepted the start
- action_done  in  1  kernel finished one firing
- total_firings  out  32  free-running count of firings since reset; wraps

## Operation
- **States:** IDLE, EVAL, FIRE, WAIT_ACT, SETTLE, DONE.
- **IDLE:** on ap_start, go to EVAL and clear the per-invocation counter `fired`.
- **EVAL:** compute the predicates, all comparisons unsigned.
  - `in_ok` = AND over i of (in_count[i] ≥ in_need[i]).
  - `out_ok` = AND over j of (out_space[j] ≥ out_need[j]).
  - Transitions are evaluated in this priority order:
    - If fired == MAX_FIRINGS: go to DONE with EXECUTED.
    - Else if in_ok && out_ok: go to FIRE.
    - Else go to DONE. The code is EXECUTED if fired > 0; otherwise WAIT_INPUT if !in_ok, else WAIT_OUTPUT. Input starvation outranks output back-pressure.
- **FIRE:** action_start = 1, held until action_ready.
  - On action_ready with action_done also high: go to SETTLE.
  - On action_ready without action_done: go to WAIT_ACT.
- **WAIT_ACT:** wait for action_done, then go to SETTLE.
- **Firing count:** on the accepted done (in FIRE or WAIT_ACT), increment fired and total_firings.
- **SETTLE:** one cycle so FIFO counts reflect the consumed and produced tokens, then go to EVAL.
- **DONE:** ap_done = ap_ready = 1 for exactly one cycle and ap_return is loaded; go to IDLE.
- **Ignored events:**
  - ap_start in any state other than IDLE.
  - action_done outside FIRE and WAIT_ACT.
- **Width rule:** fired is $clog2(MAX_FIRINGS+1) bits wide and never wraps.

## Timing
- **Reset values:** state = IDLE, ap_idle = 1, ap_done = ap_ready = 0, action_start = 0, ap_return = 0, fired = 0, total_firings = 0.
- **No-fire invocation:** ap_start at cycle t → EVAL at t+1 → ap_done at t+2. Minimum latency is 2 cycles, so done never coincides with the launch cycle.
- **Each firing:** adds at least 3 cycles (FIRE with ready and done together, SETTLE, EVAL).
- **Next launch:** ap_idle rises the cycle after ap_done, so a new ap_start is accepted from t+3.
- **Predicate sampling:** predicates are sampled only in EVAL. Count changes during FIRE, WAIT_ACT or SETTLE have no effect until the next EVAL.
- **Reset mid-operation:** on the next edge the block returns to IDLE with all reset values and action_start drops. A later action_done from the aborted kernel is ignored.

## Structure
- **Shared package:** the return codes belong in TriggerTypes, alongside the trigger's types, as a 32-bit-compatible enum: EXECUTED = 1, WAIT_INPUT = 2, WAIT_OUTPUT = 3. The responder state enum goes in the same package.
- **Sub-module:** actor_fire_predicate, purely combinational, parameterised on NUM_INPUTS, NUM_OUTPUTS and CNT_W, producing in_ok and out_ok.

## Test plan
- in_count = {0, 5}, in_need = {1, 1}, ap_start at t → ap_done at t+2, ap_return = 2 (WAIT_INPUT), action_start never asserted.
- in_count = {3, 3}, in_need = {1, 1}, out_space = 2, out_need = 1; the bench decrements counts on each done → exactly 2 firings, ap_return = 1 (EXECUTED), total_firings = 2.
- Inputs sufficient, out_space = 0, out_need = 1 → ap_return = 3 (WAIT_OUTPUT) at t+2.
- MAX_FIRINGS = 4 with unlimited tokens and space → exactly 4 action_start handshakes, then EXECUTED. A second ap_start yields 4 more; total_firings = 8.
- action_ready held low for 5 cycles → action_start stays high throughout; an ap_start pulse mid-firing is ignored (no extra firing, a single ap_done).
- ap_rst asserted in WAIT_ACT → next cycle ap_idle = 1, action_start = 0, ap_return = 0; a late action_done leaves total_firings unchanged.
